// File: rtl/score_pkg.sv
// Shared types, display codes and BCD helpers for the score display controller.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [3:0] CODE_WIN   = 4'd11;
  localparam logic [3:0] CODE_LOSS  = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_score_t;

  // Convert a binary count (0..99) to its two-digit BCD form.
  function automatic bcd_score_t to_bcd(input int unsigned v);
    bcd_score_t r;
    r.tens  = 4'((v / 10) % 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

  // BCD +1: units wrap 9->0 and carry into tens; tens wrap 9->0.
  function automatic bcd_score_t bcd_inc(input bcd_score_t s);
    bcd_score_t r;
    if (s.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = (s.tens == 4'd9) ? 4'd0 : s.tens + 4'd1;
    end else begin
      r.units = s.units + 4'd1;
      r.tens  = s.tens;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter with synchronous clear, increment enable and a
// flag telling whether the incremented value equals the target score.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int unsigned TARGET = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       hit_next
);

  bcd_score_t value_q, value_d, inc_val;

  // Next score: clear wins over increment.
  always_comb begin
    inc_val = bcd_inc(value_q);
    value_d = value_q;
    if (clr)      value_d = '0;
    else if (inc) value_d = inc_val;
  end

  // Score register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value    = value_q;
  assign hit_next = (inc_val == to_bcd(TARGET));

endmodule

// File: rtl/score_display_ctrl.sv
// Two-player score display controller: IDLE/PLAY/OVER game FSM, two BCD
// score counters and registered 7-seg digit codes.
// Optional winner blink enabled by defining SCORE_DISPLAY_BLINK_EN.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       point_l,
  input  logic       point_r,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       game_over,
  output logic       winner
);

  state_e     state_q, state_d;
  logic       win_q, win_d;
  logic       inc_l, inc_r, hit_l, hit_r;
  logic [7:0] score_l, score_r;
  logic [3:0] dig0_q, dig1_q, dig2_q, dig3_q;
  logic [3:0] dig0_d, dig1_d, dig2_d, dig3_d;
  logic       game_over_q, game_over_d, winner_q, winner_d;
  logic       visible;

  // Points only count in PLAY; start overrides points and left beats right.
  assign inc_l = (state_q == ST_PLAY) && point_l && !start;
  assign inc_r = (state_q == ST_PLAY) && point_r && !point_l && !start;

  bcd_score_counter #(.TARGET(WIN_SCORE)) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .inc      (inc_l),
    .value    (score_l),
    .hit_next (hit_l)
  );

  bcd_score_counter #(.TARGET(WIN_SCORE)) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .inc      (inc_r),
    .value    (score_r),
    .hit_next (hit_r)
  );

  // Game state: OVER is entered on the same edge the winning score lands.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    if (start) begin
      state_d = ST_PLAY;
    end else if (inc_l && hit_l) begin
      state_d = ST_OVER;
      win_d   = 1'b0;
    end else if (inc_r && hit_r) begin
      state_d = ST_OVER;
      win_d   = 1'b1;
    end
  end

  // State and latched winner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink divider: restarts visible on every entry to OVER, free-runs inside.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d == ST_OVER && state_q != ST_OVER) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (state_q == ST_OVER) begin
      if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign visible = phase_q;
`else
  assign visible = 1'b1;
`endif

  // Display codes from the registered state and scores.
  always_comb begin
    logic [3:0] wp;
    wp          = visible ? CODE_WIN : CODE_BLANK;
    dig3_d      = '0;
    dig2_d      = '0;
    dig1_d      = '0;
    dig0_d      = '0;
    game_over_d = (state_q == ST_OVER);
    winner_d    = win_q;
    case (state_q)
      ST_PLAY: begin
        {dig3_d, dig2_d} = score_l;
        {dig1_d, dig0_d} = score_r;
      end
      ST_OVER: begin
        if (win_q) begin
          {dig3_d, dig2_d} = {CODE_LOSS, CODE_LOSS};
          {dig1_d, dig0_d} = {wp, wp};
        end else begin
          {dig3_d, dig2_d} = {wp, wp};
          {dig1_d, dig0_d} = {CODE_LOSS, CODE_LOSS};
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig0_q      <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      dig3_q      <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      dig3_q      <= dig3_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign dig3      = dig3_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl (WIN_SCORE 11, BLINK_DIV 4).
module tb_score_display_ctrl;

  localparam int WIN = 11;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, point_l = 1'b0, point_r = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       game_over, winner;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb[$];

  // Reference game model: 0 idle, 1 play, 2 over.
  int   m_state, m_l, m_r, m_cnt;
  logic m_win, m_vis;

  score_display_ctrl #(.WIN_SCORE(WIN), .BLINK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .point_l(point_l), .point_r(point_r),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] dut_out();
    return {dig3, dig2, dig1, dig0, game_over, winner};
  endfunction

  function automatic logic [17:0] model_out();
    logic [3:0] d3, d2, d1, d0, wp;
    logic go;
    d3 = 0; d2 = 0; d1 = 0; d0 = 0; go = 0;
`ifdef SCORE_DISPLAY_BLINK_EN
    wp = m_vis ? 4'd11 : 4'd15;
`else
    wp = 4'd11;
`endif
    if (m_state == 1) begin
      d3 = 4'(m_l / 10); d2 = 4'(m_l % 10);
      d1 = 4'(m_r / 10); d0 = 4'(m_r % 10);
    end else if (m_state == 2) begin
      go = 1'b1;
      if (m_win) begin d3 = 12; d2 = 12; d1 = wp; d0 = wp; end
      else       begin d3 = wp; d2 = wp; d1 = 12; d0 = 12; end
    end
    return {d3, d2, d1, d0, go, m_win};
  endfunction

  task automatic model_reset();
    m_state = 0; m_l = 0; m_r = 0; m_cnt = 0; m_win = 0; m_vis = 1;
  endtask

  task automatic model_update(input logic s, input logic l, input logic r);
    int pre;
    pre = m_state;
    if (s) begin
      m_state = 1; m_l = 0; m_r = 0;
    end else if (pre == 1) begin
      if (l) begin
        m_l = (m_l + 1) % 100;
        if (m_l == WIN) begin m_state = 2; m_win = 0; end
      end else if (r) begin
        m_r = (m_r + 1) % 100;
        if (m_r == WIN) begin m_state = 2; m_win = 1; end
      end
    end
    if (m_state == 2 && pre != 2) begin
      m_cnt = 0; m_vis = 1;
    end else if (pre == 2) begin
      if (m_cnt == DIV - 1) begin m_cnt = 0; m_vis = !m_vis; end
      else m_cnt++;
    end
  endtask

  // One clock of stimulus: push expected output, clock, pop and compare.
  task automatic step(input logic s, input logic l, input logic r);
    logic [17:0] exp;
    start = s; point_l = l; point_r = r;
    sb.push_back(model_out());
    @(posedge clk);
    model_update(s, l, r);
    #1;
    exp = sb.pop_front();
    chk("sb", 32'(dut_out()), 32'(exp));
    start = 0; point_l = 0; point_r = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset state.
    #2;
    chk("reset", 32'(dut_out()), 32'h0);
    @(negedge clk); rst_n = 1;

    // Points ignored in IDLE.
    step(0, 1, 0); step(0, 0, 1); idle(2);
    chk("idle_pts", 32'(dut_out()), 32'h0);

    // 3 left, 2 right -> 0,3,0,2.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1);
    idle(2);
    chk("score_0302", 32'({dig3, dig2, dig1, dig0, game_over}), 32'({16'h0302, 1'b0}));

    // Left to 9, then carry to 10.
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    idle(1);
    chk("left_9", 32'({dig3, dig2}), 32'h09);
    step(0, 1, 0); idle(2);
    chk("carry_10", 32'({dig3, dig2}), 32'h10);

    // Simultaneous points at 10: left wins, right stays at 2.
    step(0, 1, 1); idle(2);
    chk("left_win", 32'(dut_out()), 32'({16'hBBCC, 1'b1, 1'b0}));

    // Points ignored in OVER.
    step(0, 1, 0); step(0, 0, 1); step(0, 1, 1); idle(2);

    // Start with point_r in OVER -> PLAY 0,0,0,0.
    step(1, 0, 1); idle(2);
    chk("restart", 32'(dut_out()), 32'h0);

    // Right wins; watch blink / steady glyph.
    for (int i = 0; i < WIN; i++) step(0, 0, 1);
    idle(2);
    chk("right_win", 32'({dig3, dig2, game_over, winner}), 32'({8'hCC, 1'b1, 1'b1}));
    idle(14);

    // Mid-game asynchronous reset at 5:7.
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    idle(1);
    chk("score_0507", 32'({dig3, dig2, dig1, dig0}), 32'h0507);
    @(negedge clk); rst_n = 0;
    #1;
    chk("async_rst", 32'(dut_out()), 32'h0);
    model_reset();
    sb.delete();
    @(negedge clk); rst_n = 1;
    idle(2);

    // Random play.
    step(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int v;
      v = int'($urandom_range(0, 99));
      step(v < 2, v >= 40 && v < 70, v >= 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
